// File: rtl/vector_sequencer.sv
// vector_sequencer: replays stored control words into an external datapath and
// checks the sampled result against stored expectations. Supports single-pass,
// free-running loop and single-step operation with saturating error tracking.
module vector_sequencer #(
  parameter  int CW    = 27,
  parameter  int OW    = 8,
  parameter  int DEPTH = 41,
  parameter  int LAT   = 1,
  parameter  int EW    = 6,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,       // asynchronous, active-low
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [CW-1:0] i_ld_ctrl,
  input  logic [OW-1:0] i_ld_exp,
  input  logic          i_ld_chk,
  input  logic [1:0]    i_mode,
  input  logic [AW:0]   i_len,
  input  logic          i_start,
  input  logic          i_step,
  input  logic          i_abort,
  input  logic [OW-1:0] i_obs,
  output logic [CW-1:0] o_ctrl_out,
  output logic [AW-1:0] o_vec_idx,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err_flag,
  output logic [EW-1:0] o_err_cnt,
  output logic [AW-1:0] o_first_err
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_APPLY     = 2'd1;
  localparam logic [1:0] S_WAIT_STEP = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  // Mode 2'b11 is reserved and falls through to single-pass behaviour.
  localparam logic [1:0] MODE_LOOP = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  localparam logic [AW:0] DEPTH_L     = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE     = (AW+1)'(1);
  localparam logic [3:0]  SETTLE_LAST = 4'(LAT - 1);

  // Vector storage
  logic [CW-1:0] r_ctrl_mem [DEPTH];
  logic [OW-1:0] r_exp_mem  [DEPTH];
  logic          r_chk_mem  [DEPTH];

  // Sequencer state
  logic [1:0]    r_state;
  logic [1:0]    r_mode;
  logic [AW:0]   r_len;
  logic [3:0]    r_settle;
  logic [CW-1:0] r_ctrl;
  logic [AW-1:0] r_vec_idx;
  logic          r_done;

  // Error state
  logic          r_err_flag;
  logic [EW-1:0] r_err_cnt;
  logic [AW-1:0] r_first_err;

  logic          w_idle_like;
  logic          w_ld_ok;
  logic          w_start_ok;
  logic [AW:0]   w_len_clamped;
  logic          w_settled;
  logic          w_compare;
  logic          w_mismatch;
  logic          w_last;
  logic [AW-1:0] w_next_idx;

  assign w_idle_like   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_ld_ok       = i_ld_en && w_idle_like && ({1'b0, i_ld_addr} < DEPTH_L);
  assign w_start_ok    = i_start && w_idle_like;
  assign w_len_clamped = (i_len > DEPTH_L) ? DEPTH_L : i_len;
  assign w_settled     = (r_settle == SETTLE_LAST);
  assign w_compare     = (r_state == S_APPLY) && w_settled;
  assign w_mismatch    = r_chk_mem[r_vec_idx] && (i_obs != r_exp_mem[r_vec_idx]);
  assign w_last        = ({1'b0, r_vec_idx} == (r_len - LEN_ONE));
  assign w_next_idx    = r_vec_idx + AW'(1);

  // Vector memory write port; loads are accepted only while no run is active.
  // NOTE: the vector memory has no reset branch -- its contents must survive
  // reset, and leaving it out keeps it mappable onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_ld_ok) begin
      r_ctrl_mem[i_ld_addr] <= i_ld_ctrl;
      r_exp_mem[i_ld_addr]  <= i_ld_exp;
      r_chk_mem[i_ld_addr]  <= i_ld_chk;
    end
  end

  // Sequencer FSM: run start/abort, settle timing, vector advance and ctrl word.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_mode    <= '0;
      r_len     <= '0;
      r_settle  <= '0;
      r_ctrl    <= '0;
      r_vec_idx <= '0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every branch
      // reads the pre-edge values, exactly like the flops being described.
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_mode    <= i_mode;
            r_len     <= w_len_clamped;
            r_vec_idx <= '0;
            r_settle  <= '0;
            if (i_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_ctrl  <= '0;
            end else begin
              r_state <= S_APPLY;
              r_done  <= 1'b0;
              r_ctrl  <= r_ctrl_mem[0];
            end
          end
        end

        S_APPLY: begin
          if (!w_settled) begin
            r_settle <= r_settle + 4'd1;
          end
          // Abort outranks the advance; the error block still sees the compare.
          if (i_abort) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
            r_done  <= 1'b0;
          end else if (w_settled) begin
            if (r_mode == MODE_STEP) begin
              r_state <= S_WAIT_STEP;
            end else if (!w_last) begin
              r_vec_idx <= w_next_idx;
              r_settle  <= '0;
              r_ctrl    <= r_ctrl_mem[w_next_idx];
            end else if (r_mode == MODE_LOOP) begin
              r_vec_idx <= '0;
              r_settle  <= '0;
              r_ctrl    <= r_ctrl_mem[0];
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_ctrl  <= '0;
            end
          end
        end

        S_WAIT_STEP: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
            r_done  <= 1'b0;
          end else if (i_step) begin
            if (!w_last) begin
              r_state   <= S_APPLY;
              r_vec_idx <= w_next_idx;
              r_settle  <= '0;
              r_ctrl    <= r_ctrl_mem[w_next_idx];
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_ctrl  <= '0;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Error tracking: cleared by an accepted start, updated on every compare edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_err_flag  <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (w_start_ok) begin
      r_err_flag  <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (w_compare && w_mismatch) begin
      r_err_flag <= 1'b1;
      if (!r_err_flag) begin
        r_first_err <= r_vec_idx;
      end
      if (r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + EW'(1);
      end
    end
  end

  assign o_ctrl_out  = r_ctrl;
  assign o_vec_idx   = r_vec_idx;
  assign o_busy      = (r_state == S_APPLY) || (r_state == S_WAIT_STEP);
  assign o_done      = r_done;
  assign o_err_flag  = r_err_flag;
  assign o_err_cnt   = r_err_cnt;
  assign o_first_err = r_first_err;

endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: directed bench. Stimulus tasks derive the expected
// outputs for each cycle from the sequencing rules (shadow memory, vector
// count, mode); one compare process checks them on every falling edge.
module tb_vector_sequencer;

  localparam int CW    = 27;
  localparam int OW    = 8;
  localparam int DEPTH = 41;
  localparam int LAT   = 1;
  localparam int EW    = 6;
  localparam int AW    = $clog2(DEPTH);
  localparam int EMAX  = (1 << EW) - 1;

  logic          clk;
  logic          rst_n;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [CW-1:0] ld_ctrl;
  logic [OW-1:0] ld_exp;
  logic          ld_chk;
  logic [1:0]    mode;
  logic [AW:0]   len;
  logic          start;
  logic          step;
  logic          abort;
  logic [OW-1:0] obs;
  logic [CW-1:0] ctrl_out;
  logic [AW-1:0] vec_idx;
  logic          busy;
  logic          done;
  logic          err_flag;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] first_err;

  // Shadow of what the vector memory must hold
  logic [CW-1:0] sh_ctrl [DEPTH];
  logic [OW-1:0] sh_exp  [DEPTH];
  logic          sh_chk  [DEPTH];

  // Expected outputs for the current cycle
  logic          e_busy;
  logic          e_done;
  logic          e_eflag;
  logic [EW-1:0] e_cnt;
  logic [AW-1:0] e_first;
  logic [CW-1:0] e_ctrl;
  logic [AW-1:0] e_idx;
  logic          e_idx_ok;
  logic          cmp_en;

  int n_checks = 0;
  int n_pass   = 0;
  int got_idx [8];
  int want_seq [7] = '{0, 1, 2, 0, 1, 2, 0};

  vector_sequencer #(
    .CW(CW), .OW(OW), .DEPTH(DEPTH), .LAT(LAT), .EW(EW)
  ) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_ctrl(ld_ctrl),
    .i_ld_exp(ld_exp), .i_ld_chk(ld_chk),
    .i_mode(mode), .i_len(len),
    .i_start(start), .i_step(step), .i_abort(abort),
    .i_obs(obs),
    .o_ctrl_out(ctrl_out), .o_vec_idx(vec_idx), .o_busy(busy), .o_done(done),
    .o_err_flag(err_flag), .o_err_cnt(err_cnt), .o_first_err(first_err)
  );

  // Stand-in datapath: the result is a fixed fold of the applied control word.
  function automatic logic [OW-1:0] dp(input logic [CW-1:0] c);
    return c[7:0] ^ c[15:8] ^ c[23:16];
  endfunction

  assign obs = dp(ctrl_out);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare process: every falling edge, DUT against expectations.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",      64'(busy),      64'(e_busy));
      check("done",      64'(done),      64'(e_done));
      check("ctrl_out",  64'(ctrl_out),  64'(e_ctrl));
      check("err_flag",  64'(err_flag),  64'(e_eflag));
      check("err_cnt",   64'(err_cnt),   64'(e_cnt));
      check("first_err", 64'(first_err), 64'(e_first));
      if (e_idx_ok) check("vec_idx", 64'(vec_idx), 64'(e_idx));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_expect();
    e_busy = 1'b0; e_done = 1'b0; e_eflag = 1'b0; e_cnt = '0; e_first = '0;
    e_ctrl = '0;   e_idx = '0;    e_idx_ok = 1'b1;
  endtask

  // Outcome of comparing vector k: mismatch rules applied to expected err state.
  task automatic judge(input int k);
    if (sh_chk[k] && (dp(sh_ctrl[k]) != sh_exp[k])) begin
      if (!e_eflag) e_first = AW'(k);
      e_eflag = 1'b1;
      if (int'(e_cnt) != EMAX) e_cnt = e_cnt + EW'(1);
    end
  endtask

  task automatic load(input int addr, input logic [CW-1:0] c, input logic [OW-1:0] x,
                      input logic k);
    ld_en = 1'b1; ld_addr = AW'(addr); ld_ctrl = c; ld_exp = x; ld_chk = k;
    tick();
    ld_en = 1'b0;
    if (addr < DEPTH) begin
      sh_ctrl[addr] = c; sh_exp[addr] = x; sh_chk[addr] = k;
    end
  endtask

  task automatic set_apply(input int k);
    e_busy = 1'b1; e_done = 1'b0; e_idx = AW'(k); e_idx_ok = 1'b1; e_ctrl = sh_ctrl[k];
  endtask

  task automatic set_finished();
    e_busy = 1'b0; e_done = 1'b1; e_ctrl = '0; e_idx_ok = 1'b0;
  endtask

  task automatic set_aborted();
    e_busy = 1'b0; e_done = 1'b0; e_ctrl = '0; e_idx_ok = 1'b0;
  endtask

  // Issue start; afterwards scramble mode/len, which must no longer matter.
  task automatic begin_run(input logic [1:0] m, input int l, output int n);
    mode = m; len = (AW+1)'(l); start = 1'b1;
    tick();
    start = 1'b0; mode = ~m; len = '0;
    n = (l > DEPTH) ? DEPTH : l;
    e_eflag = 1'b0; e_cnt = '0; e_first = '0;
    if (n == 0) begin
      e_busy = 1'b0; e_done = 1'b1; e_ctrl = '0; e_idx = '0; e_idx_ok = 1'b1;
    end else begin
      set_apply(0);
    end
  endtask

  // Single pass; optionally pokes start and a load while the run is busy.
  task automatic run_pass(input logic [1:0] m, input int l, input bit poke);
    int n;
    begin_run(m, l, n);
    for (int k = 0; k < n; k++) begin
      if (poke && k == 1) begin
        start = 1'b1; len = (AW+1)'(1);
        ld_en = 1'b1; ld_addr = AW'(1); ld_ctrl = '0; ld_exp = '0; ld_chk = 1'b1;
      end
      tick();
      start = 1'b0; ld_en = 1'b0;
      judge(k);
      if (k < n - 1) set_apply(k + 1);
      else set_finished();
    end
    tick();
  endtask

  // Loop mode for a number of vector periods, abort during the last one.
  task automatic run_loop(input int l, input int periods);
    int n;
    int k;
    begin_run(2'b01, l, n);
    for (int p = 0; p < periods; p++) begin
      k = p % n;
      if (p < 8) got_idx[p] = int'(vec_idx);
      if (p == periods - 1) abort = 1'b1;
      tick();
      abort = 1'b0;
      judge(k);
      if (p == periods - 1) set_aborted();
      else set_apply((k + 1) % n);
    end
    tick();
  endtask

  // Step mode: step during APPLY is ignored, then a wait, then a real step.
  task automatic run_step(input int l);
    int n;
    begin_run(2'b10, l, n);
    for (int k = 0; k < n; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      judge(k);
      if (k == 0) begin
        check("step_early_busy", 64'(busy), 64'(1));
        check("step_early_hold", 64'(ctrl_out), 64'(sh_ctrl[0]));
      end
      tick();
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      if (k < n - 1) set_apply(k + 1);
      else set_finished();
    end
    tick();
  endtask

  initial begin
    int n;
    logic [CW-1:0] c;
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_ctrl = '0; ld_exp = '0; ld_chk = 1'b0;
    mode = '0; len = '0; start = 1'b0; step = 1'b0; abort = 1'b0;
    reset_expect();
    cmp_en = 1'b1;
    #23 rst_n = 1'b1;
    tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ctrl", 64'(ctrl_out), 64'(0));

    // Fill the whole memory with matching vectors; an out-of-range load is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      c = CW'(32'h0135_79BD * (i + 1));
      load(i, c, dp(c), 1'b1);
    end
    load(45, '1, '1, 1'b1);

    // Clean 4-vector pass with start/load attempts while busy
    run_pass(2'b00, 4, 1'b1);
    check("pass_done", 64'(done), 64'(1));
    check("pass_errcnt", 64'(err_cnt), 64'(0));

    // Reserved mode with len beyond DEPTH: clamped single pass over all entries
    run_pass(2'b11, 100, 1'b0);
    check("clamp_done", 64'(done), 64'(1));

    // Wrong expectations at vectors 2 and 3
    load(2, sh_ctrl[2], ~dp(sh_ctrl[2]), 1'b1);
    load(3, sh_ctrl[3], ~dp(sh_ctrl[3]), 1'b1);
    run_pass(2'b00, 4, 1'b0);
    check("err2_flag", 64'(err_flag), 64'(1));
    check("err2_cnt", 64'(err_cnt), 64'(2));
    check("err2_first", 64'(first_err), 64'(2));

    // Same with compare disabled on vector 3
    load(3, sh_ctrl[3], ~dp(sh_ctrl[3]), 1'b0);
    run_pass(2'b00, 4, 1'b0);
    check("chk_off_cnt", 64'(err_cnt), 64'(1));

    // Loop, len=3, seven periods then abort
    run_loop(3, 7);
    for (int i = 0; i < 7; i++) check($sformatf("loop_idx%0d", i), 64'(got_idx[i]), 64'(want_seq[i]));
    check("loop_abort_busy", 64'(busy), 64'(0));
    check("loop_abort_ctrl", 64'(ctrl_out), 64'(0));
    check("loop_abort_done", 64'(done), 64'(0));
    check("loop_errcnt", 64'(err_cnt), 64'(2));

    // Step mode, len=2
    run_step(2);
    check("step_done", 64'(done), 64'(1));

    // len=0 completes on the start edge
    begin_run(2'b00, 0, n);
    check("len0_done", 64'(done), 64'(1));
    check("len0_ctrl", 64'(ctrl_out), 64'(0));
    tick();

    // Saturation: loop over two failing vectors for 72 periods
    load(0, sh_ctrl[0], ~dp(sh_ctrl[0]), 1'b1);
    load(1, sh_ctrl[1], ~dp(sh_ctrl[1]), 1'b1);
    run_loop(2, 72);
    check("sat_cnt", 64'(err_cnt), 64'(63));

    // Reset between edges mid-run, then replay from index 0
    begin_run(2'b00, 4, n);
    tick();
    judge(0);
    set_apply(1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'(ctrl_out), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_eflag", 64'(err_flag), 64'(0));
    check("rst_mid_idx", 64'(vec_idx), 64'(0));
    reset_expect();
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    run_pass(2'b00, 4, 1'b0);
    check("replay_cnt", 64'(err_cnt), 64'(3));
    check("replay_first", 64'(first_err), 64'(0));

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
